// File: rtl/rx_stock_demux.sv
// Receive-side demux: steers parsed market-data records into per-stock FWFT FIFOs.
// Each channel keeps a saturating drop counter, and a shared counter tracks out-of-range addresses.
module rx_stock_demux #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        rx_buyprice,
  input  logic [DATA_W-1:0]        rx_sellprice,
  input  logic [DATA_W-1:0]        rx_buyvol,
  input  logic [DATA_W-1:0]        rx_sellvol,
  input  logic                     rx_dv,
  output logic [NUM_CH*DATA_W-1:0] ch_buyprice,
  output logic [NUM_CH*DATA_W-1:0] ch_sellprice,
  output logic [NUM_CH*DATA_W-1:0] ch_buyvol,
  output logic [NUM_CH*DATA_W-1:0] ch_sellvol,
  output logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH-1:0]        ch_ready,
  output logic [NUM_CH*CNT_W-1:0]  ch_drop_cnt,
  output logic [CNT_W-1:0]         bad_addr_cnt
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned RecW = 4 * DATA_W;
  localparam logic [ADDR_W:0] NumChW = (ADDR_W + 1)'(NUM_CH);

  logic              addr_ok;
  logic [RecW-1:0]   rec_in;
  logic [CNT_W-1:0]  bad_q, bad_d;

  // Extra top bit keeps the compare correct when NUM_CH == 2^ADDR_W.
  assign addr_ok = ({1'b0, addr} < NumChW);
  assign rec_in  = {rx_buyprice, rx_sellprice, rx_buyvol, rx_sellvol};

  always_comb begin
    bad_d = bad_q;
    if (rx_dv && !addr_ok && (bad_q != {CNT_W{1'b1}})) begin
      bad_d = bad_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bad_q <= '0;
    end else begin
      bad_q <= bad_d;
    end
  end

  assign bad_addr_cnt = bad_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [RecW-1:0]  mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             push, pop, full, accept, reject, valid;
    logic [RecW-1:0]  head;

    assign valid  = (cnt_q != '0);
    assign full   = (cnt_q == CntW'(DEPTH));
    assign push   = rx_dv && addr_ok && (addr == ADDR_W'(i));
    assign pop    = valid && ch_ready[i];
    // A full FIFO still accepts when the same cycle frees a slot.
    assign accept = push && (!full || pop);
    assign reject = push && full && !pop;

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      drop_d   = drop_q;
      if (accept) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({accept, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      if (reject && (drop_q != {CNT_W{1'b1}})) begin
        drop_d = drop_q + 1'b1;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        drop_q   <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
        drop_q   <= drop_d;
      end
    end

    // Storage needs no reset: outputs are masked while the channel is empty.
    always_ff @(posedge clk) begin
      if (accept) begin
        mem_q[wr_ptr_q] <= rec_in;
      end
    end

    assign head = valid ? mem_q[rd_ptr_q] : '0;

    assign ch_valid[i]                        = valid;
    assign ch_buyprice[i*DATA_W +: DATA_W]    = head[3*DATA_W +: DATA_W];
    assign ch_sellprice[i*DATA_W +: DATA_W]   = head[2*DATA_W +: DATA_W];
    assign ch_buyvol[i*DATA_W +: DATA_W]      = head[1*DATA_W +: DATA_W];
    assign ch_sellvol[i*DATA_W +: DATA_W]     = head[0 +: DATA_W];
    assign ch_drop_cnt[i*CNT_W +: CNT_W]      = drop_q;
  end

endmodule

// File: tb/tb_rx_stock_demux.sv
// Bench for rx_stock_demux: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_rx_stock_demux;

  localparam int NCH = 4;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int DEP = 4;
  localparam int CW  = 4;
  localparam int SAT = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic [AW-1:0]     addr;
  logic [DW-1:0]     rx_buyprice, rx_sellprice, rx_buyvol, rx_sellvol;
  logic              rx_dv;
  logic [NCH*DW-1:0] ch_buyprice, ch_sellprice, ch_buyvol, ch_sellvol;
  logic [NCH-1:0]    ch_valid;
  logic [NCH-1:0]    ch_ready;
  logic [NCH*CW-1:0] ch_drop_cnt;
  logic [CW-1:0]     bad_addr_cnt;

  int total = 0;
  int bad   = 0;

  rx_stock_demux #(
    .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .CNT_W(CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .rx_buyprice  (rx_buyprice),
    .rx_sellprice (rx_sellprice),
    .rx_buyvol    (rx_buyvol),
    .rx_sellvol   (rx_sellvol),
    .rx_dv        (rx_dv),
    .ch_buyprice  (ch_buyprice),
    .ch_sellprice (ch_sellprice),
    .ch_buyvol    (ch_buyvol),
    .ch_sellvol   (ch_sellvol),
    .ch_valid     (ch_valid),
    .ch_ready     (ch_ready),
    .ch_drop_cnt  (ch_drop_cnt),
    .bad_addr_cnt (bad_addr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: one queue per channel, plain integer counters.
  logic [127:0] mq [NCH][$];
  int           m_drop [NCH];
  int           m_bad;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        mq[c].delete();
        m_drop[c] = 0;
      end
      m_bad = 0;
    end else begin
      bit popf [NCH];
      bit do_push;
      int tc;
      do_push = 1'b0;
      tc = 0;
      for (int c = 0; c < NCH; c++) popf[c] = (mq[c].size() > 0) && ch_ready[c];
      if (rx_dv) begin
        if (int'(addr) < NCH) begin
          tc = int'(addr);
          if (mq[tc].size() < DEP || popf[tc]) do_push = 1'b1;
          else m_drop[tc]++;
        end else begin
          m_bad++;
        end
      end
      for (int c = 0; c < NCH; c++) if (popf[c]) void'(mq[c].pop_front());
      if (do_push) mq[tc].push_back({rx_buyprice, rx_sellprice, rx_buyvol, rx_sellvol});
    end
  end

  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      logic [127:0] r;
      r = (mq[c].size() > 0) ? mq[c][0] : 128'd0;
      check($sformatf("valid[%0d]", c), 128'(ch_valid[c]), 128'(mq[c].size() > 0));
      check($sformatf("bp[%0d]", c), 128'(ch_buyprice[c*DW +: DW]), 128'(r[127:96]));
      check($sformatf("sp[%0d]", c), 128'(ch_sellprice[c*DW +: DW]), 128'(r[95:64]));
      check($sformatf("bv[%0d]", c), 128'(ch_buyvol[c*DW +: DW]), 128'(r[63:32]));
      check($sformatf("sv[%0d]", c), 128'(ch_sellvol[c*DW +: DW]), 128'(r[31:0]));
      check($sformatf("drop[%0d]", c), 128'(ch_drop_cnt[c*CW +: CW]),
            128'((m_drop[c] > SAT) ? SAT : m_drop[c]));
    end
    check("bad_addr", 128'(bad_addr_cnt), 128'((m_bad > SAT) ? SAT : m_bad));
  end

  // One clock with the given inputs; returns 1 time unit after the edge.
  task automatic cyc(input bit dv, input int a, input int bp, input int sp, input int bv,
                     input int sv, input logic [NCH-1:0] rdy);
    rx_dv = dv;
    addr = AW'(a);
    rx_buyprice = DW'(bp);
    rx_sellprice = DW'(sp);
    rx_buyvol = DW'(bv);
    rx_sellvol = DW'(sv);
    ch_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [NCH-1:0] rdy);
    cyc(1'b0, 0, 0, 0, 0, 0, rdy);
  endtask

  initial begin
    reset = 1'b1;
    rx_dv = 1'b0; addr = '0; ch_ready = '0;
    rx_buyprice = '0; rx_sellprice = '0; rx_buyvol = '0; rx_sellvol = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_valid", 128'(ch_valid), 128'(0));
    check("reset_bad", 128'(bad_addr_cnt), 128'(0));

    // Single record to channel 2.
    cyc(1'b1, 2, 'h64, 'h65, 10, 20, 4'b0000);
    idle(4'b0000);
    check("t1_valid", 128'(ch_valid), 128'(4'b0100));
    check("t1_bp2", 128'(ch_buyprice[2*DW +: DW]), 128'(32'h64));
    check("t1_sv2", 128'(ch_sellvol[2*DW +: DW]), 128'(20));
    check("t1_bp0", 128'(ch_buyprice[0 +: DW]), 128'(0));
    idle(4'b0100);
    check("t1_drained", 128'(ch_valid), 128'(0));

    // Overflow channel 1 with five records, then drain in order.
    for (int k = 1; k <= 5; k++) cyc(1'b1, 1, k, k + 100, k + 200, k + 300, 4'b0000);
    idle(4'b0000);
    check("t2_drop1", 128'(ch_drop_cnt[1*CW +: CW]), 128'(1));
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("t2_head%0d", k), 128'(ch_buyprice[1*DW +: DW]), 128'(k));
      idle(4'b0010);
    end
    check("t2_empty", 128'(ch_valid[1]), 128'(0));
    check("t2_zero", 128'(ch_sellvol[1*DW +: DW]), 128'(0));

    // Full channel 0 accepts a push when popping in the same cycle.
    for (int k = 0; k < 4; k++) cyc(1'b1, 0, 'h10 + k, 0, 0, 0, 4'b0000);
    cyc(1'b1, 0, 9, 9, 9, 9, 4'b0001);
    idle(4'b0000);
    check("t3_nodrop", 128'(ch_drop_cnt[0 +: CW]), 128'(0));
    check("t3_head", 128'(ch_buyprice[0 +: DW]), 128'('h11));
    for (int k = 0; k < 3; k++) idle(4'b0001);
    check("t3_last", 128'(ch_buyprice[0 +: DW]), 128'(9));
    idle(4'b0001);
    check("t3_empty", 128'(ch_valid[0]), 128'(0));

    // Bad addresses and an idle strobe.
    cyc(1'b1, NCH, 1, 1, 1, 1, 4'b0000);
    cyc(1'b1, 'hFF, 1, 1, 1, 1, 4'b0000);
    cyc(1'b0, 0, 7, 7, 7, 7, 4'b0000);
    idle(4'b0000);
    check("t4_bad", 128'(bad_addr_cnt), 128'(2));
    check("t4_valid", 128'(ch_valid), 128'(0));

    // Saturate channel 3's drop counter.
    for (int k = 0; k < 24; k++) cyc(1'b1, 3, k, k, k, k, 4'b0000);
    idle(4'b0000);
    check("t5_sat3", 128'(ch_drop_cnt[3*CW +: CW]), 128'(15));
    check("t5_drop2", 128'(ch_drop_cnt[2*CW +: CW]), 128'(0));
    for (int k = 0; k < 4; k++) idle(4'b1000);

    // Mid-cycle reset discards buffered records and counters.
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1, 0, 'h20 + k, 0, 0, 0, 4'b0000);
      cyc(1'b1, 3, 'h30 + k, 0, 0, 0, 4'b0000);
    end
    idle(4'b0000);
    check("t6_pre", 128'(ch_valid), 128'(4'b1001));
    #2 reset = 1'b1;
    #1;
    check("t6_valid", 128'(ch_valid), 128'(0));
    check("t6_data", 128'(ch_buyprice), 128'(0));
    check("t6_drops", 128'(ch_drop_cnt), 128'(0));
    check("t6_bad", 128'(bad_addr_cnt), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b1, 0, 'h77, 1, 2, 3, 4'b0000);
    idle(4'b0000);
    check("t6_post_valid", 128'(ch_valid), 128'(4'b0001));
    check("t6_post_bp", 128'(ch_buyprice[0 +: DW]), 128'('h77));
    idle(4'b0001);
    idle(4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_stock_demux.md
# rx_stock_demux

Parametrised receive-side demultiplexer that steers decoded market-data records (buy/sell price, buy/sell volume) from the single RX parser stream to NUM_CH per-stock channels. Each channel has its own DEPTH-entry FIFO with valid/ready handshake toward its strategy engine, so a slow consumer no longer loses data silently. The block adds saturating per-channel drop counters and a bad-address counter for monitoring. It sits between the RX message parser and the per-stock trading logic.

## Interface

- NUM_CH, 4, number of stock channels (1..256)
- ADDR_W, 8, width of stock address
- DATA_W, 32, width of each price/volume field
- DEPTH, 4, FIFO entries per channel (power of 2, >=2)
- CNT_W, 16, width of drop/bad-address counters
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- addr  in  ADDR_W  stock address of incoming record
- rx_buyprice  in  DATA_W  buy price
- rx_sellprice  in  DATA_W  sell price
- rx_buyvol  in  DATA_W  buy volume
- rx_sellvol  in  DATA_W  sell volume
- rx_dv  in  1  one-cycle strobe: record valid this cycle (no backpressure)
- ch_buyprice  out  NUM_CH*DATA_W  head-of-FIFO buy price, channel i at bits [i*DATA_W +: DATA_W]
- ch_sellprice  out  NUM_CH*DATA_W  same packing
- ch_buyvol  out  NUM_CH*DATA_W  same packing
- ch_sellvol  out  NUM_CH*DATA_W  same packing
- ch_valid  out  NUM_CH  channel i FIFO non-empty
- ch_ready  in  NUM_CH  channel i consumer accepts head entry
- ch_drop_cnt  out  NUM_CH*CNT_W  records dropped per channel, saturating
- bad_addr_cnt  out  CNT_W  records with addr >= NUM_CH, saturating

## Operation

- Record = {buyprice, sellprice, buyvol, sellvol}, 4*DATA_W bits, stored in per-channel FIFO (write ptr, read ptr, count 0..DEPTH).
- Push: rx_dv=1 and addr < NUM_CH targets channel addr. Accepted if count<DEPTH, or count==DEPTH and that channel pops in the same cycle.
- Rejected push (FIFO full, no same-cycle pop): record discarded, ch_drop_cnt[addr] += 1, saturating at 2^CNT_W-1.
- rx_dv=1 and addr >= NUM_CH: no channel written, bad_addr_cnt += 1, saturating.
- rx_dv=0: no write, no counter change; addr/data ignored.
- Pop: ch_valid[i] & ch_ready[i]; read ptr advances. ch_ready while ch_valid=0 has no effect.
- Simultaneous push and pop on the same channel: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH; count tracks full vs empty.
- First-word-fall-through: ch_valid[i] = (count_i != 0); ch_* data = entry at read ptr.
- While ch_valid[i]=0, channel i data outputs are forced to 0 (preserves the zero-when-idle behaviour downstream logic relies on).
- Channels are fully independent; pops on any set of channels may occur in one cycle.

## Timing

- Reset (async assert, sync-safe deassert by upstream): all counts/pointers 0, ch_valid=0, all ch_* data 0, ch_drop_cnt=0, bad_addr_cnt=0. Reset mid-operation discards all buffered records.
- Push latency: record sampled at edge k; ch_valid and head data visible after edge k (one cycle).
- Pop: head consumed at edge k; next entry (or zero/valid=0) visible after edge k.
- Counters update at the same edge as the rejected/bad-address strobe.
- No combinational path from ch_ready to ch_valid or data of any channel; all outputs are functions of registered state.

## Test plan

- Reset then rx_dv with addr=2, buyprice=0x64, sellprice=0x65, buyvol=10, sellvol=20 -> next cycle ch_valid=0b0100, channel 2 fields = 0x64/0x65/10/20, other channels all 0.
- ch_ready[1]=0, push 5 records (values 1..5) to channel 1, DEPTH=4 -> records 1..4 buffered, ch_drop_cnt[1]=1; then ch_ready[1]=1 -> pops 1,2,3,4 in order, ch_valid[1]=0 and data 0 afterward.
- Channel 0 full, push value 9 to channel 0 with ch_ready[0]=1 same cycle -> no drop, count stays 4, 9 emerges last after draining.
- rx_dv with addr=NUM_CH and addr=0xFF -> bad_addr_cnt=2, all ch_valid unchanged; rx_dv=0 with addr=0 -> nothing written.
- CNT_W=4, 20 rejected pushes to channel 3 -> ch_drop_cnt[3]=15 (saturated), other counters 0.
- Fill channels 0 and 3 with 2 entries each, assert reset mid-cycle -> immediately ch_valid=0, all data and counters 0; post-reset push to channel 0 behaves as from empty.
